// File: rtl/proc_pkg.sv
// Shared definitions for the decode stage of the pipelined processor.
// Contents: instruction-format widths, opcode encodings, and the ID/EX bundle type.
package proc_pkg;

  localparam int unsigned INSTR_W = 20;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned IMM_W   = INSTR_W - OP_W - 3 * REG_W;

  localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0011;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0100;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'b1011;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1100;

  typedef struct packed {
    logic             valid;
    logic [OP_W-1:0]  opcode;
    logic [REG_W-1:0] write_addr;
    logic             write_en;
    logic [REG_W-1:0] rf1;
    logic [REG_W-1:0] rf2;
    logic [IMM_W-1:0] imm;
  } id_ex_t;

endpackage

// File: rtl/decode_stage_pipe_if.sv
// IF/ID -> decode -> ID/EX signal bundle.
// master: drives in_valid, instruction, flush; observes read addresses, stall_out, ex_*.
// slave : the decode stage itself.
interface decode_stage_pipe_if #(
  parameter int unsigned INSTR_W = proc_pkg::INSTR_W,
  parameter int unsigned OP_W    = proc_pkg::OP_W,
  parameter int unsigned REG_W   = proc_pkg::REG_W
);
  localparam int unsigned ImmW = INSTR_W - OP_W - 3 * REG_W;

  logic               in_valid;
  logic [INSTR_W-1:0] instruction;
  logic               flush;
  logic [REG_W-1:0]   ReadAddressRF1;
  logic [REG_W-1:0]   ReadAddressRF2;
  logic               stall_out;
  logic               ex_valid;
  logic [OP_W-1:0]    ex_opcode;
  logic [REG_W-1:0]   ex_write_addr;
  logic               ex_write_en;
  logic [REG_W-1:0]   ex_rf1;
  logic [REG_W-1:0]   ex_rf2;
  logic [ImmW-1:0]    ex_imm;

  modport master (
    output in_valid, instruction, flush,
    input  ReadAddressRF1, ReadAddressRF2, stall_out,
    input  ex_valid, ex_opcode, ex_write_addr, ex_write_en, ex_rf1, ex_rf2, ex_imm
  );

  modport slave (
    input  in_valid, instruction, flush,
    output ReadAddressRF1, ReadAddressRF2, stall_out,
    output ex_valid, ex_opcode, ex_write_addr, ex_write_en, ex_rf1, ex_rf2, ex_imm
  );
endinterface

// File: rtl/hazard_unit.sv
// Combinational load-use hazard detector.
// Inputs : decode-side validity, source-use flags and read addresses; ID/EX valid,
//          opcode, write enable and destination.
// Output : hazard_o, high when the decoding instruction reads the register a LOAD in EX
//          is about to write.
module hazard_unit
  import proc_pkg::*;
#(
  parameter int unsigned     OP_W    = proc_pkg::OP_W,
  parameter int unsigned     REG_W   = proc_pkg::REG_W,
  parameter logic [OP_W-1:0] OP_LOAD = proc_pkg::OP_LOAD
) (
  input  logic             in_valid_i,
  input  logic             use1_i,
  input  logic             use2_i,
  input  logic [REG_W-1:0] rf1_i,
  input  logic [REG_W-1:0] rf2_i,
  input  logic             ex_valid_i,
  input  logic [OP_W-1:0]  ex_opcode_i,
  input  logic             ex_write_en_i,
  input  logic [REG_W-1:0] ex_write_addr_i,
  output logic             hazard_o
);

  logic match1, match2;

  always_comb begin
    match1   = use1_i && (rf1_i == ex_write_addr_i);
    match2   = use2_i && (rf2_i == ex_write_addr_i);
    hazard_o = in_valid_i && ex_valid_i && (ex_opcode_i == OP_LOAD) && ex_write_en_i &&
               (match1 || match2);
  end

endmodule

// File: rtl/decode_stage_pipe.sv
// Instruction decode stage with a registered ID/EX pipeline register.
// Ports: clock, reset (async, active low), bus (slave modport): IF/ID inputs, combinational
//        RF read addresses and stall_out, registered ex_* ID/EX outputs.
module decode_stage_pipe
  import proc_pkg::*;
#(
  parameter int unsigned     INSTR_W  = proc_pkg::INSTR_W,
  parameter int unsigned     OP_W     = proc_pkg::OP_W,
  parameter int unsigned     REG_W    = proc_pkg::REG_W,
  parameter logic [OP_W-1:0] OP_STORE = proc_pkg::OP_STORE,
  parameter logic [OP_W-1:0] OP_LOAD  = proc_pkg::OP_LOAD,
  parameter logic [OP_W-1:0] OP_NOP   = proc_pkg::OP_NOP
) (
  input logic               clock,
  input logic               reset,
  decode_stage_pipe_if.slave bus
);

  localparam int unsigned ImmW = INSTR_W - OP_W - 3 * REG_W;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] f1, f2, f3;
  logic [ImmW-1:0]  imm;
  logic [REG_W-1:0] rf1, rf2, dest;
  logic             write_en, use1, use2;
  logic             is_store, is_load, is_nop;
  logic             hazard;

  logic             ex_valid_q;
  logic [OP_W-1:0]  ex_opcode_q;
  logic [REG_W-1:0] ex_write_addr_q;
  logic             ex_write_en_q;
  logic [REG_W-1:0] ex_rf1_q, ex_rf2_q;
  logic [ImmW-1:0]  ex_imm_q;

  assign op  = bus.instruction[INSTR_W-1 -: OP_W];
  assign f1  = bus.instruction[INSTR_W-OP_W-1 -: REG_W];
  assign f2  = bus.instruction[INSTR_W-OP_W-REG_W-1 -: REG_W];
  assign f3  = bus.instruction[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
  assign imm = bus.instruction[ImmW-1:0];

  always_comb begin
    is_store = (op == OP_STORE);
    is_load  = (op == OP_LOAD);
    is_nop   = (op == OP_NOP);
    // STORE shifts its two sources up one field and has no destination.
    rf1      = is_store ? f1 : f2;
    rf2      = is_store ? f2 : f3;
    dest     = is_store ? '0 : f1;
    // r0 is never written, so a zero destination also suppresses the write.
    write_en = !is_store && !is_nop && (dest != '0);
    use1     = !is_nop;
    use2     = !is_nop && !is_load;
  end

  hazard_unit #(
    .OP_W   (OP_W),
    .REG_W  (REG_W),
    .OP_LOAD(OP_LOAD)
  ) u_hazard_unit (
    .in_valid_i     (bus.in_valid),
    .use1_i         (use1),
    .use2_i         (use2),
    .rf1_i          (rf1),
    .rf2_i          (rf2),
    .ex_valid_i     (ex_valid_q),
    .ex_opcode_i    (ex_opcode_q),
    .ex_write_en_i  (ex_write_en_q),
    .ex_write_addr_i(ex_write_addr_q),
    .hazard_o       (hazard)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_valid_q      <= 1'b0;
      ex_opcode_q     <= OP_NOP;
      ex_write_addr_q <= '0;
      ex_write_en_q   <= 1'b0;
      ex_rf1_q        <= '0;
      ex_rf2_q        <= '0;
      ex_imm_q        <= '0;
    end else if (bus.flush || hazard) begin
      // Kill or bubble: only validity and write enable matter, other fields hold.
      ex_valid_q    <= 1'b0;
      ex_write_en_q <= 1'b0;
    end else begin
      ex_valid_q      <= bus.in_valid;
      ex_opcode_q     <= op;
      ex_write_addr_q <= dest;
      ex_write_en_q   <= write_en && bus.in_valid;
      ex_rf1_q        <= rf1;
      ex_rf2_q        <= rf2;
      ex_imm_q        <= imm;
    end
  end

  assign bus.ReadAddressRF1 = rf1;
  assign bus.ReadAddressRF2 = rf2;
  assign bus.stall_out      = hazard && !bus.flush;
  assign bus.ex_valid       = ex_valid_q;
  assign bus.ex_opcode      = ex_opcode_q;
  assign bus.ex_write_addr  = ex_write_addr_q;
  assign bus.ex_write_en    = ex_write_en_q;
  assign bus.ex_rf1         = ex_rf1_q;
  assign bus.ex_rf2         = ex_rf2_q;
  assign bus.ex_imm         = ex_imm_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Self-checking bench for decode_stage_pipe: directed scenarios plus a randomized run
// against a field-level reference model of the decode/ID-EX behaviour.
module tb_decode_stage_pipe;
  import proc_pkg::*;

  logic   clock;
  logic   reset;
  int     vectors;
  int     miscompares;
  id_ex_t exp_st;

  decode_stage_pipe_if bus ();

  decode_stage_pipe dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Field k: 0=op, 1=f1, 2=f2, 3=f3, 4=imm; every field is four bits wide.
  function automatic logic [3:0] fld(input logic [19:0] ins, input int k);
    logic [19:0] s;
    s = ins >> (16 - 4 * k);
    return s[3:0];
  endfunction

  function automatic logic [3:0] m_rf1(input logic [19:0] ins);
    return (fld(ins, 0) == OP_STORE) ? fld(ins, 1) : fld(ins, 2);
  endfunction

  function automatic logic [3:0] m_rf2(input logic [19:0] ins);
    return (fld(ins, 0) == OP_STORE) ? fld(ins, 2) : fld(ins, 3);
  endfunction

  function automatic logic [3:0] m_dest(input logic [19:0] ins);
    return (fld(ins, 0) == OP_STORE) ? 4'd0 : fld(ins, 1);
  endfunction

  function automatic logic m_we(input logic [19:0] ins);
    logic [3:0] o;
    o = fld(ins, 0);
    return (o != OP_STORE) && (o != OP_NOP) && (m_dest(ins) != 4'd0);
  endfunction

  function automatic logic m_hazard(input id_ex_t st, input logic v, input logic [19:0] ins);
    logic [3:0] o;
    logic       reads1, reads2;
    o      = fld(ins, 0);
    reads1 = (o != OP_NOP);
    reads2 = (o != OP_NOP) && (o != OP_LOAD);
    if (!(v && st.valid && st.opcode == OP_LOAD && st.write_en)) return 1'b0;
    return (reads1 && m_rf1(ins) == st.write_addr) || (reads2 && m_rf2(ins) == st.write_addr);
  endfunction

  function automatic id_ex_t m_next(input id_ex_t st, input logic v, input logic [19:0] ins,
                                    input logic fl);
    id_ex_t n;
    n = st;
    if (fl || m_hazard(st, v, ins)) begin
      n.valid    = 1'b0;
      n.write_en = 1'b0;
    end else begin
      n.valid      = v;
      n.opcode     = fld(ins, 0);
      n.write_addr = m_dest(ins);
      n.write_en   = m_we(ins) && v;
      n.rf1        = m_rf1(ins);
      n.rf2        = m_rf2(ins);
      n.imm        = fld(ins, 4);
    end
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic v, input logic [19:0] ins, input logic fl);
    bus.in_valid    = v;
    bus.instruction = ins;
    bus.flush       = fl;
    #3;
  endtask

  task automatic clk_edge();
    @(posedge clock);
    if (!reset) exp_st = '0;
    else exp_st = m_next(exp_st, bus.in_valid, bus.instruction, bus.flush);
    #1;
  endtask

  function automatic logic [19:0] rand_instr();
    logic [3:0] o;
    case ($urandom_range(0, 3))
      0:       o = OP_LOAD;
      1:       o = OP_STORE;
      2:       o = OP_NOP;
      default: o = 4'($urandom_range(0, 15));
    endcase
    return {o, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 15))};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    exp_st = '0;
    set_in(1'b0, 20'h0, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got=%0b exp=0", bus.ex_valid);
    end
    vectors++;
    if (bus.ex_opcode !== OP_NOP || bus.ex_write_addr !== 4'd0 || bus.ex_write_en !== 1'b0 ||
        bus.ex_rf1 !== 4'd0 || bus.ex_rf2 !== 4'd0 || bus.ex_imm !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_fields got=%0h/%0h/%0b/%0h/%0h/%0h exp=0", bus.ex_opcode,
               bus.ex_write_addr, bus.ex_write_en, bus.ex_rf1, bus.ex_rf2, bus.ex_imm);
    end
    @(negedge clock);
    reset = 1'b1;
    clk_edge();
    set_in(1'b0, 20'h0, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_valid got=%0b exp=0", bus.ex_valid);
    end
  endtask

  task automatic test_store_remap();
    set_in(1'b1, 20'hC3570, 1'b0);
    vectors++;
    if (bus.ReadAddressRF1 !== 4'h3 || bus.ReadAddressRF2 !== 4'h5) begin
      miscompares++;
      $display("FAIL store_rd got=%0h,%0h exp=3,5", bus.ReadAddressRF1, bus.ReadAddressRF2);
    end
    clk_edge();
    set_in(1'b0, 20'h0, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b1 || bus.ex_write_en !== 1'b0 || bus.ex_opcode !== 4'hC) begin
      miscompares++;
      $display("FAIL store_ex got=v%0b we%0b op%0h exp=v1 we0 opc", bus.ex_valid,
               bus.ex_write_en, bus.ex_opcode);
    end
  endtask

  task automatic test_alu_decode();
    set_in(1'b1, 20'h12469, 1'b0);
    vectors++;
    if (bus.ReadAddressRF1 !== 4'h4 || bus.ReadAddressRF2 !== 4'h6) begin
      miscompares++;
      $display("FAIL alu_rd got=%0h,%0h exp=4,6", bus.ReadAddressRF1, bus.ReadAddressRF2);
    end
    clk_edge();
    set_in(1'b0, 20'h0, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b1 || bus.ex_write_addr !== 4'h2 || bus.ex_write_en !== 1'b1 ||
        bus.ex_imm !== 4'h9) begin
      miscompares++;
      $display("FAIL alu_ex got=v%0b wa%0h we%0b imm%0h exp=v1 wa2 we1 imm9", bus.ex_valid,
               bus.ex_write_addr, bus.ex_write_en, bus.ex_imm);
    end
  endtask

  task automatic test_load_use();
    set_in(1'b1, 20'hB5100, 1'b0);
    clk_edge();
    set_in(1'b1, 20'h17530, 1'b0);
    vectors++;
    if (bus.stall_out !== 1'b1) begin
      miscompares++; $display("FAIL lu_stall got=%0b exp=1", bus.stall_out);
    end
    clk_edge();
    set_in(1'b1, 20'h17530, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b0 || bus.stall_out !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_bubble got=v%0b st%0b exp=v0 st0", bus.ex_valid, bus.stall_out);
    end
    clk_edge();
    set_in(1'b0, 20'h0, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b1 || bus.ex_write_addr !== 4'h7 || bus.ex_opcode !== 4'h1) begin
      miscompares++;
      $display("FAIL lu_add got=v%0b wa%0h op%0h exp=v1 wa7 op1", bus.ex_valid,
               bus.ex_write_addr, bus.ex_opcode);
    end
  endtask

  task automatic test_no_false_hazard();
    logic [19:0] firsts [3];
    logic [19:0] seconds[3];
    firsts  = '{20'hB5100, 20'hB0100, 20'hB5100};
    seconds = '{20'hC2300, 20'h17030, 20'h00550};
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, firsts[i], 1'b0);
      clk_edge();
      set_in(1'b1, seconds[i], 1'b0);
      vectors++;
      if (bus.stall_out !== 1'b0) begin
        miscompares++; $display("FAIL nofalse_%0d got=%0b exp=0", i, bus.stall_out);
      end
      clk_edge();
      set_in(1'b0, 20'h0, 1'b0);
      vectors++;
      if (bus.ex_valid !== 1'b1 || bus.ex_opcode !== fld(seconds[i], 0)) begin
        miscompares++;
        $display("FAIL nofalse_ex_%0d got=v%0b op%0h exp=v1 op%0h", i, bus.ex_valid,
                 bus.ex_opcode, fld(seconds[i], 0));
      end
    end
  endtask

  task automatic test_flush_priority();
    set_in(1'b1, 20'hB5100, 1'b0);
    clk_edge();
    set_in(1'b1, 20'h17530, 1'b1);
    vectors++;
    if (bus.stall_out !== 1'b0) begin
      miscompares++; $display("FAIL flush_stall got=%0b exp=0", bus.stall_out);
    end
    clk_edge();
    set_in(1'b0, 20'h0, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b0 || bus.ex_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ex got=v%0b we%0b exp=v0 we0", bus.ex_valid, bus.ex_write_en);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_in(1'b1, 20'hB5100, 1'b0);
    clk_edge();
    set_in(1'b1, 20'h17530, 1'b0);
    vectors++;
    if (bus.stall_out !== 1'b1) begin
      miscompares++; $display("FAIL rst_pre_stall got=%0b exp=1", bus.stall_out);
    end
    #1 reset = 1'b0;
    exp_st = '0;
    #1;
    vectors++;
    if (bus.stall_out !== 1'b0 || bus.ex_valid !== 1'b0 || bus.ex_opcode !== OP_NOP ||
        bus.ex_write_addr !== 4'd0 || bus.ex_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async got=st%0b v%0b op%0h wa%0h we%0b exp=all0", bus.stall_out,
               bus.ex_valid, bus.ex_opcode, bus.ex_write_addr, bus.ex_write_en);
    end
    bus.in_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    clk_edge();
    set_in(1'b0, 20'h0, 1'b0);
    vectors++;
    if (bus.ex_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_release got=%0b exp=0", bus.ex_valid);
    end
  endtask

  task automatic test_random(input int n);
    logic        v, fl, hold, es;
    logic [19:0] ins;
    hold = 1'b0;
    v    = 1'b0;
    ins  = '0;
    for (int i = 0; i < n; i++) begin
      // A stalled instruction stays in IF/ID, as the front end would hold it.
      if (!hold) begin
        v   = ($urandom_range(0, 9) != 0);
        ins = rand_instr();
      end
      fl = ($urandom_range(0, 9) == 0);
      set_in(v, ins, fl);
      es = m_hazard(exp_st, v, ins) && !fl;
      vectors++;
      if (bus.ReadAddressRF1 !== m_rf1(ins) || bus.ReadAddressRF2 !== m_rf2(ins)) begin
        miscompares++;
        $display("FAIL rnd_rd[%0d] got=%0h,%0h exp=%0h,%0h", i, bus.ReadAddressRF1,
                 bus.ReadAddressRF2, m_rf1(ins), m_rf2(ins));
      end
      vectors++;
      if (bus.stall_out !== es) begin
        miscompares++; $display("FAIL rnd_stall[%0d] got=%0b exp=%0b", i, bus.stall_out, es);
      end
      vectors++;
      if (bus.ex_valid !== exp_st.valid || bus.ex_write_en !== exp_st.write_en) begin
        miscompares++;
        $display("FAIL rnd_vld[%0d] got=v%0b we%0b exp=v%0b we%0b", i, bus.ex_valid,
                 bus.ex_write_en, exp_st.valid, exp_st.write_en);
      end
      if (exp_st.valid) begin
        vectors++;
        if (bus.ex_opcode !== exp_st.opcode || bus.ex_write_addr !== exp_st.write_addr ||
            bus.ex_rf1 !== exp_st.rf1 || bus.ex_rf2 !== exp_st.rf2 ||
            bus.ex_imm !== exp_st.imm) begin
          miscompares++;
          $display("FAIL rnd_ex[%0d] got=%0h/%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h/%0h", i,
                   bus.ex_opcode, bus.ex_write_addr, bus.ex_rf1, bus.ex_rf2, bus.ex_imm,
                   exp_st.opcode, exp_st.write_addr, exp_st.rf1, exp_st.rf2, exp_st.imm);
        end
      end
      hold = es;
      clk_edge();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_store_remap();
    test_alu_decode();
    test_load_use();
    test_no_false_hazard();
    test_flush_priority();
    test_reset_mid_stall();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Parametrised instruction-decode stage with a registered ID/EX pipeline register for the pipelined processor.
- Extracts opcode and register fields and drives register-file read addresses combinationally.
- Applies the STORE field remap, detects load-use hazards and inserts one bubble per hazard.
- Supports flush, with one cycle of latency from IF/ID to ID/EX.

Parameters:
- INSTR_W, 20, instruction width.
- OP_W, 4, opcode width in the instruction MSBs.
- REG_W, 4, register-address field width.
- OP_STORE, 4'b1100, store opcode; reads the [15:12] and [11:8] fields, no register write.
- OP_LOAD, 4'b1011, load opcode; reads RF1 only, writes the destination register.
- OP_NOP, 4'b0000, no reads, no write.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  IF/ID register holds a valid instruction.
- instruction  in  INSTR_W  IF/ID instruction.
- flush  in  1  kill the instruction currently in decode (branch taken).
- ReadAddressRF1  out  REG_W  combinational RF port-1 address.
- ReadAddressRF2  out  REG_W  combinational RF port-2 address.
- stall_out  out  1  combinational; hold PC and IF/ID this cycle.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_opcode  out  OP_W  registered opcode.
- ex_write_addr  out  REG_W  registered destination register.
- ex_write_en  out  1  registered register-file write enable.
- ex_rf1  out  REG_W  registered RF1 address (forwarding compare).
- ex_rf2  out  REG_W  registered RF2 address.
- ex_imm  out  INSTR_W-OP_W-3*REG_W  registered immediate (low bits).

Behaviour:
- Field map: op=[19:16], f1=[15:12], f2=[11:8], f3=[7:4], imm=[3:0]. Generalised as: op in the MSBs, then three REG_W fields, immediate in the remainder.
- Non-STORE: RF1=f2, RF2=f3, dest=f1. STORE: RF1=f1, RF2=f2, dest=0, write_en=0. Read addresses are purely combinational from `instruction`, with no gating.
- Source usage:
  - STORE uses RF1 and RF2.
  - LOAD uses RF1 only.
  - NOP uses neither.
  - All other opcodes use both.
- write_en=1 for all opcodes except STORE and NOP, and is forced to 0 when dest==0.
- Hazard: hazard = in_valid & ex_valid & (ex_opcode==OP_LOAD) & ex_write_en & ((use1 & RF1==ex_write_addr) | (use2 & RF2==ex_write_addr)).
- stall_out = hazard & ~flush.
- Each rising edge, priority order:
  - flush: ex_valid<=0, ex_write_en<=0.
  - else hazard: bubble; ex_valid<=0, ex_write_en<=0.
  - else: ID/EX <= decoded fields; ex_valid<=in_valid; ex_write_en<=decoded write_en & in_valid.
- When a bubble is inserted, the other ex_* fields may hold their previous values. The bench checks them only when ex_valid=1.
- A stall lasts exactly one cycle per load-use pair: the bubble clears the EX LOAD, so the hazard drops next cycle.
- in_valid=0: ex_valid<=0; no hazard and no stall.
- Reset (async assert, sync release by the system): all ex_* <= 0, ex_opcode<=OP_NOP. Reset mid-stall clears the bubble state, and stall_out drops immediately because ex_valid=0.
- Latency: decode to ID/EX is 1 cycle; read addresses have 0 latency.

Decomposition:
- Package `proc_pkg`:
  - OP_W, REG_W and INSTR_W constants.
  - opcode localparams (OP_STORE, OP_LOAD, OP_NOP, ALU opcodes).
  - a packed struct for the ID/EX bundle {valid, opcode, write_addr, write_en, rf1, rf2, imm}.
- One sub-module, `hazard_unit`: purely combinational load-use comparator producing `hazard` from the decoded sources and the ID/EX fields. This keeps it reusable when forwarding is added.

Test Plan:
- Reset: drive reset=0 mid-run -> all ex_*=0 and stall_out=0 asynchronously. After release with in_valid=0, ex_valid stays 0.
- STORE remap: instruction 20'hC_3_5_7_0 -> RF1=3, RF2=5 same cycle. Next cycle: ex_write_en=0, ex_opcode=4'hC, ex_valid=1.
- ALU decode: 20'h1_2_4_6_9 -> RF1=4, RF2=6. Next cycle: ex_write_addr=2, ex_write_en=1, ex_imm=9.
- Load-use: LOAD 20'hB_5_1_0_0, then ADD 20'h1_7_5_3_0 -> stall_out=1 for one cycle and ex_valid=0 bubble. The cycle after, the ADD enters ID/EX with ex_write_addr=7.
- No false hazard:
  - LOAD to r5, then STORE 20'hC_2_3_0_0 -> no stall.
  - LOAD with dest 0 -> no stall.
  - LOAD to r5, then NOP -> no stall.
- Flush priority: flush=1 during a load-use hazard cycle -> stall_out=0 and ex_valid=0 next cycle.
